// File: rtl/display_producto_7seg_if.sv
// Handshake bundle between the Booth multiplier and the 7-segment display stage.
interface display_producto_7seg_if;
  logic [15:0] producto;
  logic        valido;
  logic        ocupado;

  modport master (output producto, output valido, input ocupado);
  modport slave  (input producto, input valido, output ocupado);
endinterface

// File: rtl/display_producto_7seg.sv
// Converts a signed 16-bit product to sign + 5 BCD digits (double dabble)
// and scans it onto an 8-digit common-anode 7-segment display.
module display_producto_7seg #(
  parameter int SCAN_DIV = 100000
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  display_producto_7seg_if.slave        bus,
  output logic [7:0]                    anodo,
  output logic [6:0]                    catodo
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t        state_q;
  logic          sign_q;
  logic [15:0]   mag_q;
  logic [19:0]   bcd_q;
  logic [4:0]    iter_q;
  logic          ocupado_q;
  logic [19:0]   dispBcd_q;
  logic          dispSign_q;

  logic [CW-1:0] scanCnt_q;
  logic [2:0]    scanIdx_q;
  logic [7:0]    anodo_q;
  logic [6:0]    catodo_q;

  logic [15:0]   absIn;
  logic [19:0]   bcdAdj;
  logic [2:0]    msd;
  logic [3:0]    digitSel;
  logic          slotEn_d;
  logic [6:0]    slotSeg_d;

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    segOf = 7'b1000000;
      4'd1:    segOf = 7'b1111001;
      4'd2:    segOf = 7'b0100100;
      4'd3:    segOf = 7'b0110000;
      4'd4:    segOf = 7'b0011001;
      4'd5:    segOf = 7'b0010010;
      4'd6:    segOf = 7'b0000010;
      4'd7:    segOf = 7'b1111000;
      4'd8:    segOf = 7'b0000000;
      4'd9:    segOf = 7'b0010000;
      default: segOf = 7'h7F;
    endcase
  endfunction

  // Two's-complement negation of 16'h8000 yields 16'h8000, read as 32768 unsigned.
  assign absIn = bus.producto[15] ? (~bus.producto + 16'd1) : bus.producto;

  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcdAdj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ocupado_q  <= 1'b0;
      dispBcd_q  <= '0;
      dispSign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valido) begin
            sign_q    <= bus.producto[15];
            mag_q     <= absIn;
            bcd_q     <= '0;
            iter_q    <= '0;
            ocupado_q <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q  <= (bcdAdj << 1) | {19'd0, mag_q[15]};
          mag_q  <= {mag_q[14:0], 1'b0};
          iter_q <= iter_q + 5'd1;
          if (iter_q == 5'd15) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          dispBcd_q  <= bcd_q;
          dispSign_q <= sign_q && (bcd_q != 20'd0);
          ocupado_q  <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          ocupado_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Highest nonzero digit; everything above it is blanked.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (dispBcd_q[i*4 +: 4] != 4'd0) begin
        msd = 3'(i);
      end
    end
  end

  always_comb begin
    digitSel  = 4'd0;
    slotEn_d  = 1'b0;
    slotSeg_d = 7'h7F;
    case (scanIdx_q)
      3'd0: digitSel = dispBcd_q[3:0];
      3'd1: digitSel = dispBcd_q[7:4];
      3'd2: digitSel = dispBcd_q[11:8];
      3'd3: digitSel = dispBcd_q[15:12];
      3'd4: digitSel = dispBcd_q[19:16];
      default: digitSel = 4'd0;
    endcase
    if (scanIdx_q <= 3'd4) begin
      slotEn_d  = (scanIdx_q <= msd);
      slotSeg_d = segOf(digitSel);
    end else if (scanIdx_q == 3'd5) begin
      slotEn_d  = dispSign_q;
      slotSeg_d = 7'b0111111;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      scanCnt_q <= '0;
      scanIdx_q <= 3'd0;
      anodo_q   <= 8'hFF;
      catodo_q  <= 7'h7F;
    end else begin
      if (scanCnt_q == CW'(SCAN_DIV - 1)) begin
        scanCnt_q <= '0;
        scanIdx_q <= scanIdx_q + 3'd1;
      end else begin
        scanCnt_q <= scanCnt_q + 1'b1;
      end
      anodo_q  <= slotEn_d ? ~(8'd1 << scanIdx_q) : 8'hFF;
      catodo_q <= slotEn_d ? slotSeg_d : 7'h7F;
    end
  end

  assign bus.ocupado = ocupado_q;
  assign anodo       = anodo_q;
  assign catodo      = catodo_q;

endmodule

// File: tb/tb_display_producto_7seg.sv
// Directed bench for display_producto_7seg: busy timing, BCD digits, sign, blanking, reset.
module tb_display_producto_7seg;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG3 = 7'b0110000;
  localparam logic [6:0] SEG4 = 7'b0011001;
  localparam logic [6:0] SEG5 = 7'b0010010;
  localparam logic [6:0] SEG6 = 7'b0000010;
  localparam logic [6:0] SEG7 = 7'b1111000;
  localparam logic [6:0] SEG8 = 7'b0000000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BLK  = 7'h7F;
  localparam int FRAME = 8 * 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] anodo;
  logic [6:0] catodo;
  int         checks = 0;
  int         failures = 0;
  int         busy;

  logic [6:0] catSeen [8];
  logic [6:0] expFrame [8];
  logic [7:0] seenMask;
  int         badScan;

  display_producto_7seg_if bus();

  display_producto_7seg #(.SCAN_DIV(4)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus),
    .anodo     (anodo),
    .catodo    (catodo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] value);
    @(negedge clk);
    bus.producto = value;
    bus.valido   = 1'b1;
    @(negedge clk);
    bus.valido   = 1'b0;
  endtask

  task automatic measureBusy(output int count);
    count = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.ocupado) count++;
      else if (count > 0) break;
      @(negedge clk);
    end
  endtask

  task automatic setExpected(input logic [6:0] s7, s6, s5, s4, s3, s2, s1, s0);
    expFrame[7] = s7; expFrame[6] = s6; expFrame[5] = s5; expFrame[4] = s4;
    expFrame[3] = s3; expFrame[2] = s2; expFrame[1] = s1; expFrame[0] = s0;
  endtask

  // One full scan: record what each enabled slot drove and flag illegal anode patterns.
  task automatic captureFrame();
    for (int p = 0; p < 8; p++) catSeen[p] = BLK;
    seenMask = 8'h00;
    badScan  = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if ($countones(~anodo) > 1) badScan++;
      if (anodo == 8'hFF && catodo != BLK) badScan++;
      for (int p = 0; p < 8; p++) begin
        if (anodo[p] == 1'b0) begin
          catSeen[p]  = catodo;
          seenMask[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkFrame(input string name);
    logic [7:0] expMask;
    expMask = 8'h00;
    captureFrame();
    for (int p = 0; p < 8; p++) begin
      checkOutput($sformatf("%s_slot%0d", name, p), {25'd0, catSeen[p]}, {25'd0, expFrame[p]});
      if (expFrame[p] != BLK) expMask[p] = 1'b1;
    end
    checkOutput({name, "_mask"}, {24'd0, seenMask}, {24'd0, expMask});
    checkOutput({name, "_scan"}, badScan, 0);
  endtask

  initial begin
    reset        = 1'b0;
    bus.valido   = 1'b0;
    bus.producto = 16'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_anodo", {24'd0, anodo}, 32'hFF);
    checkOutput("rst_catodo", {25'd0, catodo}, 32'h7F);
    checkOutput("rst_ocupado", {31'd0, bus.ocupado}, 0);
    reset = 1'b1;

    $display("[TB] reset value shows 0");
    setExpected(BLK, BLK, BLK, BLK, BLK, BLK, BLK, SEG0);
    checkFrame("init");
    checkOutput("init_ocupado", {31'd0, bus.ocupado}, 0);

    $display("[TB] +56");
    applyStimulus(16'd56);
    measureBusy(busy);
    checkOutput("busy_56", busy, 17);
    setExpected(BLK, BLK, BLK, BLK, BLK, BLK, SEG5, SEG6);
    checkFrame("p56");

    $display("[TB] -56");
    applyStimulus(16'hFFC8);
    measureBusy(busy);
    checkOutput("busy_m56", busy, 17);
    setExpected(BLK, BLK, DASH, BLK, BLK, BLK, SEG5, SEG6);
    checkFrame("m56");

    $display("[TB] -32768");
    applyStimulus(16'h8000);
    measureBusy(busy);
    checkOutput("busy_min", busy, 17);
    setExpected(BLK, BLK, DASH, SEG3, SEG2, SEG7, SEG6, SEG8);
    checkFrame("min");

    $display("[TB] zero");
    applyStimulus(16'd0);
    measureBusy(busy);
    checkOutput("busy_zero", busy, 17);
    setExpected(BLK, BLK, BLK, BLK, BLK, BLK, BLK, SEG0);
    checkFrame("zero");

    // Extra strobes four cycles in and on the LOAD edge must both be dropped.
    $display("[TB] busy drop");
    applyStimulus(16'd56);
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ocupado) busy++;
      if (i == 3 || i == 16) begin
        bus.producto = 16'd99;
        bus.valido   = 1'b1;
      end else begin
        bus.valido   = 1'b0;
      end
      @(negedge clk);
    end
    bus.valido = 1'b0;
    checkOutput("busy_drop", busy, 17);
    setExpected(BLK, BLK, BLK, BLK, BLK, BLK, SEG5, SEG6);
    checkFrame("drop");

    $display("[TB] reset mid-conversion");
    applyStimulus(16'd4321);
    repeat (7) @(negedge clk);
    checkOutput("mid_ocupado_pre", {31'd0, bus.ocupado}, 1);
    reset = 1'b0;
    #1;
    checkOutput("mid_ocupado", {31'd0, bus.ocupado}, 0);
    checkOutput("mid_anodo", {24'd0, anodo}, 32'hFF);
    checkOutput("mid_catodo", {25'd0, catodo}, 32'h7F);
    @(negedge clk);
    reset = 1'b1;
    setExpected(BLK, BLK, BLK, BLK, BLK, BLK, BLK, SEG0);
    checkFrame("postrst");

    $display("[TB] 1234");
    applyStimulus(16'd1234);
    measureBusy(busy);
    checkOutput("busy_1234", busy, 17);
    setExpected(BLK, BLK, BLK, BLK, SEG1, SEG2, SEG3, SEG4);
    checkFrame("v1234");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
